// File: rtl/gpu_mem_responder_if.sv
// rtl/gpu_mem_responder_if.sv - GPU request bus and SRAM pin bundle for gpu_mem_responder
interface gpu_mem_responder_if;
    logic [17:0] iMEM_ADDR;
    logic        iMEM_READ;
    logic        iMEM_WRITE;
    logic [15:0] iGPU_DATA;
    logic [15:0] oGPU_DATA;
    logic        oGPU_VALID;
    logic        oWRITE_ACK;
    logic        oMEM_BUSY;
    logic [17:0] SRAM_ADDR;
    logic [15:0] oSRAM_DQ;
    logic        oSRAM_DQ_OE;
    logic [15:0] iSRAM_DQ;
    logic        SRAM_CE_N;
    logic        SRAM_OE_N;
    logic        SRAM_WE_N;
    logic        SRAM_UB_N;
    logic        SRAM_LB_N;

    modport master (
        output iMEM_ADDR, iMEM_READ, iMEM_WRITE, iGPU_DATA, iSRAM_DQ,
        input  oGPU_DATA, oGPU_VALID, oWRITE_ACK, oMEM_BUSY,
        input  SRAM_ADDR, oSRAM_DQ, oSRAM_DQ_OE,
        input  SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N
    );

    modport slave (
        input  iMEM_ADDR, iMEM_READ, iMEM_WRITE, iGPU_DATA, iSRAM_DQ,
        output oGPU_DATA, oGPU_VALID, oWRITE_ACK, oMEM_BUSY,
        output SRAM_ADDR, oSRAM_DQ, oSRAM_DQ_OE,
        output SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N
    );
endinterface

// File: rtl/gpu_mem_responder.sv
// rtl/gpu_mem_responder.sv - z-buffer read/write/RMW responder for a 256Kx16 async SRAM
// Every pin is a flop; pin values are decoded from the next state so they line up with the state.
module gpu_mem_responder #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic               clock,
    input  logic               reset,
    gpu_mem_responder_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        READ     = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4
    } state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rmw_q, rmw_d;
    logic [15:0] wdata_q, wdata_d;
    logic [17:0] addr_q, addr_d;
    logic [15:0] dq_q, dq_d;
    logic [15:0] rdata_q, rdata_d;
    logic        valid_q, valid_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic        dq_oe_q, dq_oe_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic        accept;
    logic        read_done;

    assign accept    = (state_q == IDLE) && !busy_q && (bus.iMEM_READ || bus.iMEM_WRITE);
    assign read_done = (state_q == READ) && (cnt_q == 4'd1);

    // Async reset also releases WE_N at once, cutting short any write pulse in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rmw_q   <= 1'b0;
            wdata_q <= 16'd0;
            addr_q  <= 18'd0;
            dq_q    <= 16'd0;
            rdata_q <= 16'd0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            dq_oe_q <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rmw_q   <= rmw_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            dq_q    <= dq_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            dq_oe_q <= dq_oe_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        cnt_d   = cnt_q;
        rmw_d   = rmw_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = bus.iMEM_ADDR;
                    wdata_d = bus.iGPU_DATA;
                    rmw_d   = bus.iMEM_READ && bus.iMEM_WRITE;
                    if (bus.iMEM_READ) begin
                        state_d = READ;
                        cnt_d   = WAIT_LD;
                    end else begin
                        state_d = WR_SETUP;
                    end
                end
            end
            READ: begin
                if (cnt_q == 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = rmw_q ? WR_SETUP : IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR_SETUP: begin
                state_d = WR_PULSE;
                cnt_d   = WAIT_LD;
            end
            WR_PULSE: begin
                if (cnt_q == 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR_HOLD: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : outputs
        busy_d  = (state_d != IDLE);
        ce_n_d  = (state_d == IDLE);
        oe_n_d  = (state_d != READ);
        we_n_d  = (state_d != WR_PULSE);
        dq_oe_d = (state_d == WR_SETUP) || (state_d == WR_PULSE) || (state_d == WR_HOLD);
        valid_d = read_done;
        ack_d   = (state_q == WR_HOLD);
        rdata_d = read_done ? bus.iSRAM_DQ : rdata_q;
        // Write data reaches the pins on entry to WR_SETUP and stays through WR_HOLD.
        dq_d    = ((state_d == WR_SETUP) && (state_q != WR_SETUP)) ? wdata_d : dq_q;
    end

    assign bus.oGPU_DATA   = rdata_q;
    assign bus.oGPU_VALID  = valid_q;
    assign bus.oWRITE_ACK  = ack_q;
    assign bus.oMEM_BUSY   = busy_q;
    assign bus.SRAM_ADDR   = addr_q;
    assign bus.oSRAM_DQ    = dq_q;
    assign bus.oSRAM_DQ_OE = dq_oe_q;
    assign bus.SRAM_CE_N   = ce_n_q;
    assign bus.SRAM_OE_N   = oe_n_q;
    assign bus.SRAM_WE_N   = we_n_q;
    assign bus.SRAM_UB_N   = ce_n_q;
    assign bus.SRAM_LB_N   = ce_n_q;
endmodule

// File: doc/gpu_mem_responder.md
# gpu_mem_responder

Memory-side responder for the GPU pixel/z-buffer request interface. Accepts single-cycle read, write, or read-then-write requests (18-bit word address, 16-bit data: bits [15:14] depth, [13:0] colour) from the z-buffer stage and executes them against the board's 256K×16 asynchronous SRAM. Returns read data with a one-cycle valid strobe and reports completion of writes. Sits between the z-buffer pipeline and the SRAM pins.

## Interface
- WAIT_CYCLES, 1, SRAM access cycles per read and WE_N low-pulse width per write; legal range 1–15.
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; forces the reset state immediately.
- iMEM_ADDR  in  18  request word address.
- iMEM_READ  in  1  read request.
- iMEM_WRITE  in  1  write request; when asserted together with iMEM_READ, the request is a read-then-write (RMW).
- iGPU_DATA  in  16  write data from the GPU.
- oGPU_DATA  out  16  read data returned to the GPU.
- oGPU_VALID  out  1  one-cycle strobe; oGPU_DATA holds new read data.
- oWRITE_ACK  out  1  one-cycle strobe; the write phase has completed.
- oMEM_BUSY  out  1  responder is not accepting requests.
- SRAM_ADDR  out  18  SRAM address.
- oSRAM_DQ  out  16  SRAM write data.
- oSRAM_DQ_OE  out  1  tristate enable for oSRAM_DQ (top level drives the inout pin).
- iSRAM_DQ  in  16  SRAM read data.
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low SRAM controls.

## Operation
- All outputs are registered.
- States: IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD.
- A request is accepted at a rising edge when the state is IDLE, oMEM_BUSY=0, and iMEM_READ or iMEM_WRITE is 1.
  - At acceptance, iMEM_ADDR and iGPU_DATA are latched and the RMW flag is captured.
  - Requests presented while busy are ignored, not queued.
  - The initiator holds each request for exactly one accepted cycle.
- IDLE→READ when iMEM_READ=1 (read or RMW). IDLE→WR_SETUP on a write-only request.
- READ:
  - Drives CE_N=OE_N=UB_N=LB_N=0, WE_N=1, oSRAM_DQ_OE=0, SRAM_ADDR=latched address.
  - A 4-bit counter is loaded with WAIT_CYCLES at acceptance and decrements each cycle.
  - At the edge where the counter equals 1: iSRAM_DQ is captured into oGPU_DATA, oGPU_VALID is set for one cycle, and the next state is WR_SETUP if RMW, otherwise IDLE.
- WR_SETUP (1 cycle):
  - Drives OE_N=1, WE_N=1, CE_N=UB_N=LB_N=0.
  - oSRAM_DQ=latched data, oSRAM_DQ_OE=1.
- WR_PULSE (WAIT_CYCLES cycles): WE_N=0; address and data held.
- WR_HOLD (1 cycle):
  - WE_N=1; data still driven.
  - At exit: oWRITE_ACK is set for one cycle and the next state is IDLE.
- In IDLE: all _N outputs are 1 and oSRAM_DQ_OE=0. SRAM_ADDR, oSRAM_DQ and oGPU_DATA hold their last values.
- oMEM_BUSY=1 in every state except IDLE.
- Reset values: state IDLE, oGPU_DATA=0, oGPU_VALID=0, oWRITE_ACK=0, oMEM_BUSY=0, SRAM_ADDR=0, oSRAM_DQ=0, oSRAM_DQ_OE=0, all SRAM _N outputs 1, counter 0.
- Reset during WR_PULSE forces WE_N high asynchronously. The contents of the addressed word are then undefined. No strobe is issued for the aborted request.

## Timing
- Acceptance edge is T0. oMEM_BUSY rises after T0.
- Read: oGPU_VALID is high during cycle T0+WAIT_CYCLES → T0+WAIT_CYCLES+1. oMEM_BUSY falls at the same edge.
- A new request can therefore be accepted at edge T0+WAIT_CYCLES+1, while oGPU_VALID is still high.
- Write-only: WR_SETUP, then WAIT_CYCLES cycles of WR_PULSE, then WR_HOLD. oWRITE_ACK and busy-low occur at edge T0+WAIT_CYCLES+2.
- RMW: oGPU_VALID as for a read, but busy stays high. oWRITE_ACK occurs at edge T0+2·WAIT_CYCLES+2, and busy falls at that edge.
- oGPU_VALID and oWRITE_ACK are never asserted for more than one consecutive cycle per request.
- Both strobes are never asserted in the same cycle.
- Back-to-back throughput:
  - Reads: one per WAIT_CYCLES+1 cycles.
  - Writes: one per WAIT_CYCLES+3 cycles.

## Test plan
- Reset: assert reset mid-cycle → all outputs take their reset values without waiting for a clock edge; SRAM_WE_N=1, oMEM_BUSY=0.
- Read, WAIT_CYCLES=1: SRAM model holds 16'hC000 at address 1; pulse iMEM_READ with iMEM_ADDR=1 → oGPU_VALID is high one cycle, one edge after acceptance, with oGPU_DATA=16'hC000; SRAM_OE_N is low exactly one cycle.
- Write then read, WAIT_CYCLES=3:
  - Write 16'h0F00 to address 2 → SRAM_WE_N low exactly 3 cycles; oSRAM_DQ=16'h0F00 stable from WR_SETUP through WR_HOLD; oWRITE_ACK at T0+5.
  - A following read of address 2 → returns 16'h0F00.
- RMW, WAIT_CYCLES=2: address 5 holds 16'h4123; request with both strobes and iGPU_DATA=16'h8ABC → oGPU_VALID with 16'h4123 at T0+2; oWRITE_ACK at T0+6; the model then holds 16'h8ABC.
- Busy drop: issue a read, then pulse a write to address 7 while oMEM_BUSY=1 → address 7 is unchanged and no oWRITE_ACK is issued; re-issuing the write after busy falls succeeds.
- Reset during WR_PULSE → SRAM_WE_N goes high immediately; state returns to IDLE; no strobe is issued; the next read is accepted normally.
